// File: rtl/ffstdp_update_ctrl.sv
// ffstdp_update_ctrl
// Sequencer for the FF-STDP weight-update datapath. A START pulse at the end of
// a training sample triggers a sweep over every synapse {post, pre}. For each
// synapse the controller:
//   - reads the weight, the pre-spike count and the post-spike count,
//   - latches them for the combinational update datapath,
//   - writes the updated weight back to the weight SRAM.
// The weight SRAM is shared with the inference core through a REQ/GNT handshake.
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_start                   sweep request pulse, honoured only in idle
//   i_is_pos_in               sample polarity, sampled with i_start
//   i_is_train_in             training enable, sampled with i_start
//   o_busy, o_done            status; o_done is a one-cycle completion pulse
//   o_bus_req, i_bus_gnt      weight-SRAM ownership handshake
//   o_sram_*, i_sram_rdata    weight SRAM port, address {post_idx, pre_idx}
//   o_pre_cnt_addr, i_pre_cnt_rdata    pre-count memory (1-cycle read latency)
//   o_post_cnt_addr, i_post_cnt_rdata  post-count memory (1-cycle read latency)
//   o_upd_*, i_upd_wsyn_new   operands to, and result from, the update datapath
module ffstdp_update_ctrl #(
  parameter int unsigned N_PRE          = 784,
  parameter int unsigned N_POST         = 256,
  parameter int unsigned PRE_ADDR_W     = 10,
  parameter int unsigned POST_ADDR_W    = 8,
  parameter int unsigned WEIGHT_WIDTH   = 8,
  parameter int unsigned PRE_CNT_WIDTH  = 8,
  parameter int unsigned POST_CNT_WIDTH = 7
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_start,
  input  logic                              i_is_pos_in,
  input  logic                              i_is_train_in,
  output logic                              o_busy,
  output logic                              o_done,
  output logic                              o_bus_req,
  input  logic                              i_bus_gnt,
  output logic                              o_sram_cs,
  output logic                              o_sram_we,
  output logic [PRE_ADDR_W+POST_ADDR_W-1:0] o_sram_addr,
  output logic [WEIGHT_WIDTH-1:0]           o_sram_wdata,
  input  logic [WEIGHT_WIDTH-1:0]           i_sram_rdata,
  output logic [PRE_ADDR_W-1:0]             o_pre_cnt_addr,
  input  logic [PRE_CNT_WIDTH-1:0]          i_pre_cnt_rdata,
  output logic [POST_ADDR_W-1:0]            o_post_cnt_addr,
  input  logic [POST_CNT_WIDTH-1:0]         i_post_cnt_rdata,
  output logic                              o_upd_tref_event,
  output logic                              o_upd_is_pos,
  output logic                              o_upd_is_train,
  output logic [PRE_CNT_WIDTH-1:0]          o_upd_pre_cnt,
  output logic [POST_CNT_WIDTH-1:0]         o_upd_post_cnt,
  output logic [WEIGHT_WIDTH-1:0]           o_upd_wsyn_curr,
  input  logic [WEIGHT_WIDTH-1:0]           i_upd_wsyn_new
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StRd,
    StEval,
    StWr,
    StNext,
    StDone
  } state_e;

  // Last valid index values; wrap happens here, not at the power-of-two boundary.
  localparam logic [PRE_ADDR_W-1:0]  PreLast  = PRE_ADDR_W'(N_PRE - 1);
  localparam logic [POST_ADDR_W-1:0] PostLast = POST_ADDR_W'(N_POST - 1);

  state_e                     r_state;
  state_e                     w_state_next;
  logic [PRE_ADDR_W-1:0]      r_pre_idx;
  logic [POST_ADDR_W-1:0]     r_post_idx;
  logic                       r_is_pos;
  logic                       r_is_train;
  logic [PRE_CNT_WIDTH-1:0]   r_pre_cnt;
  logic [POST_CNT_WIDTH-1:0]  r_post_cnt;
  logic [WEIGHT_WIDTH-1:0]    r_wsyn_curr;

  logic                       w_pre_last;
  logic                       w_post_last;
  logic                       w_sweep_start;
  logic                       w_delta_zero;
  logic                       w_rd_issue;
  logic                       w_wr_issue;

  assign w_pre_last    = (r_pre_idx == PreLast);
  assign w_post_last   = (r_post_idx == PostLast);
  assign w_sweep_start = (r_state == StIdle) && i_start && i_is_train_in;
  // Only the low five bits of the pre count feed the weight delta.
  assign w_delta_zero  = (i_pre_cnt_rdata[4:0] == 5'd0);

  // State register and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_pre_idx   <= '0;
      r_post_idx  <= '0;
      r_is_pos    <= 1'b0;
      r_is_train  <= 1'b0;
      r_pre_cnt   <= '0;
      r_post_cnt  <= '0;
      r_wsyn_curr <= '0;
    end else begin
      r_state <= w_state_next;

      if (w_sweep_start) begin
        r_is_pos   <= i_is_pos_in;
        r_is_train <= 1'b1;
        r_pre_idx  <= '0;
        r_post_idx <= '0;
      end

      // Read data arrives the cycle after RD; these values persist across grant
      // loss until the write finally issues.
      if (r_state == StEval) begin
        r_wsyn_curr <= i_sram_rdata;
        r_pre_cnt   <= i_pre_cnt_rdata;
        r_post_cnt  <= i_post_cnt_rdata;
      end

      // After the final synapse the indices are left in place; the next sweep
      // start clears them.
      if (r_state == StNext) begin
        if (!w_pre_last) begin
          r_pre_idx <= r_pre_idx + PRE_ADDR_W'(1);
        end else if (!w_post_last) begin
          r_pre_idx  <= '0;
          r_post_idx <= r_post_idx + POST_ADDR_W'(1);
        end
      end
    end
  end

  // Next-state logic and control outputs.
  always_comb begin
    w_state_next = r_state;
    w_rd_issue   = 1'b0;
    w_wr_issue   = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_next = i_is_train_in ? StReq : StDone;
        end
      end
      StReq: begin
        if (i_bus_gnt) begin
          w_state_next = StRd;
        end
      end
      StRd: begin
        if (i_bus_gnt) begin
          w_rd_issue   = 1'b1;
          w_state_next = StEval;
        end
      end
      StEval: begin
        w_state_next = w_delta_zero ? StNext : StWr;
      end
      StWr: begin
        if (i_bus_gnt) begin
          w_wr_issue   = 1'b1;
          w_state_next = StNext;
        end
      end
      StNext: begin
        w_state_next = (w_pre_last && w_post_last) ? StDone : StRd;
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_comb begin
    o_busy           = (r_state != StIdle) && (r_state != StDone);
    o_done           = (r_state == StDone);
    // Ownership is held from REQ through NEXT so the sweep is not re-arbitrated
    // between synapses.
    o_bus_req        = o_busy;
    // A reset asserted mid-sweep must not let an access slip out in that cycle.
    o_sram_cs        = (w_rd_issue || w_wr_issue) && !i_rst;
    o_sram_we        = w_wr_issue && !i_rst;
    o_sram_addr      = {r_post_idx, r_pre_idx};
    o_sram_wdata     = (r_state == StWr) ? i_upd_wsyn_new : '0;
    o_pre_cnt_addr   = r_pre_idx;
    o_post_cnt_addr  = r_post_idx;
    o_upd_tref_event = (r_state == StWr);
    o_upd_is_pos     = r_is_pos;
    o_upd_is_train   = r_is_train;
    o_upd_pre_cnt    = r_pre_cnt;
    o_upd_post_cnt   = r_post_cnt;
    o_upd_wsyn_curr  = r_wsyn_curr;
  end

endmodule

// File: tb/tb_ffstdp_update_ctrl.sv
// Testbench for ffstdp_update_ctrl: a 4x2 synapse array (pre index deliberately
// one bit wider than needed) with behavioural weight/count memories and a toy
// update datapath. Expected transactions and latencies come from a sweep model.
module tb_ffstdp_update_ctrl;

  localparam int NPRE  = 4;
  localparam int NPOST = 2;
  localparam int PREW  = 3;
  localparam int POSTW = 1;
  localparam int AW    = PREW + POSTW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          is_pos_in;
  logic          is_train_in;
  logic          busy;
  logic          done;
  logic          bus_req;
  logic          gnt;
  logic          cs;
  logic          we;
  logic [AW-1:0] addr;
  logic [7:0]    wdata;
  logic [7:0]    rdata;
  logic [PREW-1:0]  pre_addr;
  logic [7:0]       pre_rdata;
  logic [POSTW-1:0] post_addr;
  logic [6:0]       post_rdata;
  logic       tref;
  logic       upd_is_pos;
  logic       upd_is_train;
  logic [7:0] upd_pre;
  logic [6:0] upd_post;
  logic [7:0] upd_wsyn;
  logic [7:0] upd_new;
  logic       load;

  logic [7:0] wimg [0:15];
  logic [7:0] wmem [0:15];
  logic [7:0] pcnt [0:7];
  logic [6:0] qcnt [0:1];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int viol = 0;
  int done_n = 0;
  int req_n = 0;
  int cs_n = 0;
  int rd_q[$];
  int wa_q[$];
  int wd_q[$];
  int exp_rd[$];
  int exp_wa[$];
  int exp_wd[$];

  always #5 clk = ~clk;

  ffstdp_update_ctrl #(
    .N_PRE(NPRE), .N_POST(NPOST), .PRE_ADDR_W(PREW), .POST_ADDR_W(POSTW),
    .WEIGHT_WIDTH(8), .PRE_CNT_WIDTH(8), .POST_CNT_WIDTH(7)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_is_pos_in(is_pos_in),
    .i_is_train_in(is_train_in), .o_busy(busy), .o_done(done), .o_bus_req(bus_req),
    .i_bus_gnt(gnt), .o_sram_cs(cs), .o_sram_we(we), .o_sram_addr(addr),
    .o_sram_wdata(wdata), .i_sram_rdata(rdata), .o_pre_cnt_addr(pre_addr),
    .i_pre_cnt_rdata(pre_rdata), .o_post_cnt_addr(post_addr),
    .i_post_cnt_rdata(post_rdata), .o_upd_tref_event(tref), .o_upd_is_pos(upd_is_pos),
    .o_upd_is_train(upd_is_train), .o_upd_pre_cnt(upd_pre), .o_upd_post_cnt(upd_post),
    .o_upd_wsyn_curr(upd_wsyn), .i_upd_wsyn_new(upd_new)
  );

  // Toy update datapath; any function that mixes every operand will do.
  function automatic logic [7:0] dp(logic [7:0] w, logic [7:0] pc, logic [6:0] qc,
                                    logic pos, logic tr);
    return (w + pc + {1'b0, qc}) ^ {pos, 6'd0, tr};
  endfunction

  assign upd_new = dp(upd_wsyn, upd_pre, upd_post, upd_is_pos, upd_is_train);

  // Weight SRAM and count memories, all with one cycle of read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load) begin
      for (int i = 0; i < 16; i++) wmem[i] <= wimg[i];
    end else if (cs && we) begin
      wmem[addr] <= wdata;
    end
    if (cs && !we) rdata <= wmem[addr];
    pre_rdata  <= pcnt[pre_addr];
    post_rdata <= qcnt[post_addr];
  end

  // Bus monitor, sampling just before each rising edge.
  always @(negedge clk) begin
    #4;
    if (cs && !we) rd_q.push_back(int'(addr));
    if (cs && we) begin
      wa_q.push_back(int'(addr));
      wd_q.push_back(int'(wdata));
      if (!tref) viol++;
    end
    if (cs && (!gnt || !bus_req)) viol++;
    if (busy && done) viol++;
    if (done) done_n++;
    if (bus_req) req_n++;
    if (cs) cs_n++;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs_vec();
    return 64'({busy, done, bus_req, cs, we, addr, wdata, pre_addr, post_addr, tref,
                upd_is_pos, upd_is_train, upd_pre, upd_post, upd_wsyn});
  endfunction

  task automatic load_images();
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic rand_data(input bit force_nonzero);
    for (int i = 0; i < 16; i++) wimg[i] = 8'($urandom);
    for (int i = 0; i < NPRE; i++) begin
      if (!force_nonzero && $urandom_range(0, 2) == 0) pcnt[i] = {3'($urandom), 5'd0};
      else pcnt[i] = 8'($urandom_range(1, 31)) | {3'($urandom), 5'd0};
    end
    for (int i = 0; i < NPOST; i++) qcnt[i] = 7'($urandom);
  endtask

  // Expected reads, writes and constant-grant latency of one training sweep.
  task automatic model(input bit pos, output int lat);
    exp_rd.delete();
    exp_wa.delete();
    exp_wd.delete();
    lat = 2;
    for (int q = 0; q < NPOST; q++) begin
      for (int p = 0; p < NPRE; p++) begin
        int a;
        a = q * (1 << PREW) + p;
        exp_rd.push_back(a);
        if (pcnt[p] % 32 != 0) begin
          exp_wa.push_back(a);
          exp_wd.push_back(int'(dp(wimg[a], pcnt[p], qcnt[q], pos, 1'b1)));
          lat += 4;
        end else begin
          lat += 3;
        end
      end
    end
  endtask

  task automatic start_pulse(input bit pos, input bit train);
    @(negedge clk);
    start = 1'b1;
    is_pos_in = pos;
    is_train_in = train;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    is_pos_in = 1'($urandom);
    is_train_in = 1'($urandom);
  endtask

  // Waits for DONE. Optionally randomises the grant, injects a START while busy,
  // or withholds the grant for 5 cycles at the first write.
  task automatic wait_done(input bit rgnt, input int inj_at, input bit inj_pos,
                           input bit drop, output int lat);
    bit dropped = 1'b0;
    logic [7:0] hold;
    lat = -1;
    for (int i = 0; i < 4000; i++) begin
      if (drop && !dropped && tref) begin
        dropped = 1'b1;
        hold = upd_wsyn;
        gnt = 1'b0;
        for (int k = 0; k < 5; k++) begin
          #1;
          check("hold_cs", cs, 0);
          check("hold_tref", tref, 1);
          check("hold_wsyn", upd_wsyn, hold);
          @(negedge clk);
        end
        gnt = 1'b1;
      end
      if (done) begin
        lat = cyc - start_cyc;
        break;
      end
      if (rgnt) gnt = ($urandom_range(0, 3) != 0);
      if (i == inj_at) begin
        start = 1'b1;
        is_pos_in = inj_pos;
        is_train_in = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    gnt = 1'b1;
    if (lat < 0) check("done_timeout", 0, 1);
    // A START during the DONE cycle must be ignored.
    start = 1'b1;
    is_train_in = 1'b1;
    is_pos_in = ~upd_is_pos;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("idle_after_done", busy, 0);
  endtask

  task automatic compare(input int rd0, input int wr0);
    check("n_reads", rd_q.size() - rd0, exp_rd.size());
    check("n_writes", wa_q.size() - wr0, exp_wa.size());
    for (int i = 0; i < exp_rd.size(); i++)
      if (rd0 + i < rd_q.size()) check("rd_addr", rd_q[rd0+i], exp_rd[i]);
    for (int i = 0; i < exp_wa.size(); i++) begin
      if (wr0 + i < wa_q.size()) begin
        check("wr_addr", wa_q[wr0+i], exp_wa[i]);
        check("wr_data", wd_q[wr0+i], exp_wd[i]);
      end
    end
  endtask

  task automatic run_sweep(input bit pos, input bit rgnt, input int inj_at, input bit drop);
    int rd0, wr0, d0, lat, exp_lat;
    load_images();
    rd0 = rd_q.size();
    wr0 = wa_q.size();
    d0 = done_n;
    model(pos, exp_lat);
    start_pulse(pos, 1'b1);
    wait_done(rgnt, inj_at, ~pos, drop, lat);
    if (!rgnt) check("latency", lat, exp_lat + (drop ? 5 : 0));
    compare(rd0, wr0);
    check("done_count", done_n - d0, 1);
    check("upd_is_pos", upd_is_pos, pos);
    check("upd_is_train", upd_is_train, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, c0, r0, w0, lat, nwr;
    rst = 1'b1;
    start = 1'b0;
    is_pos_in = 1'b0;
    is_train_in = 1'b0;
    gnt = 1'b1;
    load = 1'b0;
    for (int i = 0; i < 8; i++) pcnt[i] = '0;
    qcnt[0] = '0;
    qcnt[1] = '0;
    for (int i = 0; i < 16; i++) wimg[i] = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs_vec(), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", outs_vec(), 0);

    // Uniform counts of 3, weights 0x10: every synapse is written.
    for (int i = 0; i < 16; i++) wimg[i] = 8'h10;
    for (int i = 0; i < NPRE; i++) pcnt[i] = 8'd3;
    qcnt[0] = 7'd5;
    qcnt[1] = 7'd9;
    run_sweep(1'b1, 1'b0, -1, 1'b0);

    // Zero-delta synapses at pre 0 and 2 skip the write.
    pcnt[0] = 8'd0; pcnt[1] = 8'd5; pcnt[2] = 8'd0; pcnt[3] = 8'd5;
    run_sweep(1'b0, 1'b0, -1, 1'b0);

    // Non-training START: immediate DONE, no bus activity.
    d0 = done_n;
    c0 = cs_n;
    r0 = req_n;
    start_pulse(1'b1, 1'b0);
    wait_done(1'b0, -1, 1'b0, 1'b0, lat);
    check("notrain_latency", lat, 1);
    check("notrain_cs", cs_n - c0, 0);
    check("notrain_req", req_n - r0, 0);
    check("notrain_done", done_n - d0, 1);

    // Grant withheld for 5 cycles in WR.
    rand_data(1'b1);
    run_sweep(1'b1, 1'b0, -1, 1'b1);

    // START with opposite polarity while busy.
    rand_data(1'b0);
    run_sweep(1'b0, 1'b0, 10, 1'b0);
    rand_data(1'b0);
    run_sweep(1'b1, 1'b0, 20, 1'b0);

    // Reset during the third synapse's WR.
    rand_data(1'b1);
    load_images();
    w0 = wa_q.size();
    d0 = done_n;
    start_pulse(1'b1, 1'b1);
    nwr = 0;
    for (int i = 0; i < 500; i++) begin
      if (tref) begin
        nwr++;
        if (nwr == 3) break;
      end
      @(negedge clk);
    end
    check("third_wr_reached", nwr, 3);
    rst = 1'b1;
    #1;
    check("rst_no_cs", cs, 0);
    check("rst_no_we", we, 0);
    @(negedge clk);
    check("post_rst_outputs", outs_vec(), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_writes", wa_q.size() - w0, 2);
    check("rst_no_done", done_n - d0, 0);
    run_sweep(1'b0, 1'b0, -1, 1'b0);

    // Randomised sweeps, constant and random grant.
    for (int n = 0; n < 6; n++) begin
      rand_data(1'b0);
      run_sweep(1'($urandom), n[0], -1, 1'b0);
    end

    check("protocol_violations", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
